qspi_flash_resp: RTL and testbench
==================================

# qspi_flash_resp

Synthesizable QSPI NOR-flash responder: the device end of the SoC `qspi0` master interface (SCK, CS_n, DQ[3:0]). It oversamples the flash pins on the system clock, decodes SPI mode-0 read commands, fetches bytes from a synchronous byte-wide memory port, and shifts them back to the master. It is used in the FPGA build and in simulation as an on-chip flash image, replacing an external flash part.

## Interface
Parameters:
- `ADDR_W`, 24: memory address width. The low `ADDR_W` bits of the 24-bit SPI address are used and the upper bits are ignored.
- `JEDEC_ID`, 24'hEF4018: value returned by opcode 0x9F, MSB first.
- `DUMMY_CYC`, 8: number of dummy SCK cycles for 0x0B and 0x6B.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_sck`  in  1  SPI clock from the master; asynchronous to `clk`.
- `spi_cs_n`  in  1  chip select, active low; asynchronous to `clk`.
- `spi_dq_i`  in  4  DQ pad inputs.
- `spi_dq_o`  out  4  DQ pad output values.
- `spi_dq_oe`  out  4  DQ output enables, active high.
- `mem_req`  out  1  single-cycle fetch strobe.
- `mem_addr`  out  ADDR_W  fetch address; valid while `mem_req` is high.
- `mem_rdata`  in  8  fetched byte; valid exactly one `clk` cycle after `mem_req`.
- `busy`  out  1  high while the synchronized CS_n is low.
- `cmd_err`  out  1  single-cycle pulse when an unsupported opcode is received.

## Operation
- **Synchronization:** `spi_sck`, `spi_cs_n` and `spi_dq_i` pass through 2-flop synchronizers. SCK rise and fall events come from a third stage that feeds an edge detector.
- **Sampling:** SPI mode 0. Input bits are sampled on SCK rise; output bits change on SCK fall. Everything is MSB first.
- **States:** IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
- **IDLE:** moves to CMD when synchronized CS_n falls; the bit counter clears.
- **CMD:** shifts in 8 bits from DQ[0]. On the 8th rise it decodes the opcode:
  - 0x03 goes to ADDR.
  - 0x0B goes to ADDR.
  - 0x9F goes to ID.
  - 0x6B goes to ADDR, only when the macro below is defined.
  - Any other opcode goes to IGNORE and pulses `cmd_err`.
- **ADDR:** shifts in 24 bits from DQ[0]. On the 24th rise it latches the address and issues `mem_req` with `mem_addr` set to that address.
  - Opcode 0x03 then goes to DATA.
  - Opcodes 0x0B and 0x6B go to DUMMY.
- **DUMMY:** counts `DUMMY_CYC` rises, then goes to DATA.
- **DATA:** each SCK fall drives the next output bit.
  - Single-bit mode: output on DQ[1], `spi_dq_oe`=4'b0010, 8 falls per byte.
  - At the first fall of each byte, the shift register loads the prefetched byte and the block issues `mem_req` for address+1.
  - The address wraps modulo 2^ADDR_W.
- **ID:** outputs the 3 bytes of `JEDEC_ID` on DQ[1], then repeats them cyclically. No `mem_req` is issued.
- **IGNORE:** `spi_dq_oe`=0; the block waits for CS_n to go high.
- **CS_n high in any state:** return to IDLE. `spi_dq_oe` goes to 0, any partial byte is discarded, and no further `mem_req` is issued. If CS_n rises in the same cycle as an SCK edge event, CS_n wins.
- **`busy`:** reflects the synchronized CS_n.

## Timing
- **Reset values:** every output is 0, the state is IDLE, and the shift, address and counter registers are all 0.
- **Pin-to-edge latency:** a pin transition is seen as an edge event 3 `clk` cycles later.
  - `spi_dq_o` is updated in the cycle after the fall event, i.e. 4 `clk` after the SCK pin falls.
  - The master must keep SCK high and low for at least 6 `clk` each. Behaviour at faster SCK is undefined.
- **Memory latency:** `mem_rdata` is captured 1 cycle after `mem_req`, which is always before the next fall event.
- **First data bit:** driven on the fall that follows the last address rise (for 0x03) or the last dummy rise (for 0x0B/0x6B).
- **CS_n deassert:** `spi_dq_oe` reaches 0 no later than 4 `clk` after the CS_n pin rises.
- **`cmd_err`:** asserts in the cycle after the 8th-rise event.

## Configuration
- `QSPI_FLASH_RESP_QUAD_EN` defined:
  - Opcode 0x6B (quad output fast read) is supported.
  - Command and address are received on DQ[0], followed by `DUMMY_CYC` dummy cycles.
  - Data is driven on DQ[3:0], high nibble first, 2 falls per byte, with `spi_dq_oe`=4'b1111.
- Macro undefined: 0x6B is treated as an unsupported opcode (IGNORE state plus a `cmd_err` pulse), and `spi_dq_oe` never exceeds 4'b0010.

## Test plan
- **READ from 0x000010:** opcode 0x03, memory returns 0xA5 then 0x5A. Required: DQ[1] carries 1010_0101 then 0101_1010, and `mem_req` addresses are 0x000010, 0x000011, 0x000012.
- **JEDEC ID:** opcode 0x9F, 32 SCK cycles. Required: bytes 0xEF, 0x40, 0x18, 0xEF, and no `mem_req`.
- **Address wrap:** opcode 0x0B, address 0xFFFFFF, 8 dummy cycles, read 2 bytes. Required: `mem_addr` sequence 0xFFFFFF, 0x000000, 0x000001.
- **Unsupported opcode:** opcode 0x55, followed by 16 more SCK cycles. Required: one `cmd_err` pulse, `spi_dq_oe`=0 throughout; then CS_n high followed by 0x9F returns 0xEF.
- **Abort mid-byte:** CS_n rises after 4 data bits of a 0x03 read. Required: `spi_dq_oe`=0 within 4 `clk`, `busy`=0, and the next 0x03 transaction is byte-correct.
- **Quad read (macro defined):** opcode 0x6B, address 0, 8 dummy cycles, `mem_rdata`=0x3C. Required: DQ=4'h3 then 4'hC, with `spi_dq_oe`=4'hF during data.

Source files
------------

// File: rtl/qspi_flash_resp.sv
// qspi_flash_resp: SPI mode-0 read-only NOR-flash responder fed from a synchronous byte-wide memory port.
// Define QSPI_FLASH_RESP_QUAD_EN to add opcode 0x6B (quad output fast read); otherwise 0x6B is rejected.
module qspi_flash_resp #(
    parameter int          ADDR_W    = 24,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    parameter int          DUMMY_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic [3:0]        spi_dq_i,
    output logic [3:0]        spi_dq_o,
    output logic [3:0]        spi_dq_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);
`ifdef QSPI_FLASH_RESP_QUAD_EN
    localparam bit QUAD = 1'b1;
`else
    localparam bit QUAD = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_IGNORE
    } state_t;

    logic [2:0]        sck_q, cs_q;
    logic [3:0]        dq_s1_q, dq_s2_q;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [23:0]       addr_sh_q, addr_sh_d;
    logic [7:0]        op_q, op_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [7:0]        pre_q, pre_d;
    logic              req_dly_q;
    logic [3:0]        dq_o_q, dq_o_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              cmd_err_q, cmd_err_d;

    logic        sck_rise, sck_fall, cs_high, cs_fall, din, quad, unused_dq;
    logic [23:0] addr_full;
    logic [7:0]  id_byte, src;
    logic [7:0]  last_bit;

    // Third SCK/CS stage exists only to form edge events against the synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q   <= '0;
            cs_q    <= '1;
            dq_s1_q <= '0;
            dq_s2_q <= '0;
        end else begin
            sck_q   <= {sck_q[1:0], spi_sck};
            cs_q    <= {cs_q[1:0], spi_cs_n};
            dq_s1_q <= spi_dq_i;
            dq_s2_q <= dq_s1_q;
        end
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign cs_high   = cs_q[1];
    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign din       = dq_s2_q[0];
    assign unused_dq = ^dq_s2_q[3:1];
    assign addr_full = {addr_sh_q[22:0], din};
    assign quad      = QUAD && (op_q == 8'h6B);
    assign last_bit  = quad ? 8'd1 : 8'd7;

    always_comb begin
        case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            addr_sh_q  <= '0;
            op_q       <= '0;
            id_idx_q   <= '0;
            pre_q      <= '0;
            req_dly_q  <= 1'b0;
            dq_o_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            addr_sh_q  <= addr_sh_d;
            op_q       <= op_d;
            id_idx_q   <= id_idx_d;
            pre_q      <= pre_d;
            req_dly_q  <= mem_req_q;
            dq_o_q     <= dq_o_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        addr_sh_d  = addr_sh_q;
        op_d       = op_q;
        id_idx_d   = id_idx_q;
        pre_d      = req_dly_q ? mem_rdata : pre_q;
        dq_o_d     = dq_o_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        cmd_err_d  = 1'b0;
        src        = sr_q;
        // CS_n high is checked first so it beats a coincident SCK edge event.
        if (cs_high && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dq_o_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d    = '0;
                    id_idx_d = '0;
                    if (cs_fall) state_d = S_CMD;
                end
                S_CMD: if (sck_rise) begin
                    sr_d  = {sr_q[6:0], din};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        cnt_d = '0;
                        op_d  = {sr_q[6:0], din};
                        case ({sr_q[6:0], din})
                            8'h03, 8'h0B: state_d = S_ADDR;
                            8'h9F:        state_d = S_ID;
                            8'h6B: begin
                                if (QUAD) begin
                                    state_d = S_ADDR;
                                end else begin
                                    state_d   = S_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            end
                            default: begin
                                state_d   = S_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: if (sck_rise) begin
                    addr_sh_d = addr_full;
                    cnt_d     = cnt_q + 8'd1;
                    if (cnt_q == 8'd23) begin
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_full[ADDR_W-1:0];
                        state_d    = (op_q == 8'h03 || DUMMY_CYC == 0) ? S_DATA : S_DUMMY;
                    end
                end
                S_DUMMY: if (sck_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(DUMMY_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA, S_ID: if (sck_fall) begin
                    // Byte boundary: take the prefetched (or ID) byte and prefetch the next address.
                    if (cnt_q == '0) begin
                        if (state_q == S_DATA) begin
                            src        = pre_q;
                            mem_req_d  = 1'b1;
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                        end else begin
                            src      = id_byte;
                            id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                        end
                    end
                    if (quad) begin
                        dq_o_d = src[7:4];
                        sr_d   = {src[3:0], 4'h0};
                    end else begin
                        dq_o_d = {2'b00, src[7], 1'b0};
                        sr_d   = {src[6:0], 1'b0};
                    end
                    cnt_d = (cnt_q == last_bit) ? 8'd0 : cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        spi_dq_oe = '0;
        if (state_q == S_DATA) spi_dq_oe = quad ? 4'hF : 4'b0010;
        else if (state_q == S_ID) spi_dq_oe = 4'b0010;
    end

    assign spi_dq_o = dq_o_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = ~cs_high;

endmodule

// File: tb/tb_qspi_flash_resp.sv
// Bench for qspi_flash_resp: table of directed transactions, a CS/SCK coincidence sequence,
// and random transactions checked against a rule-level model of the flash protocol.
module tb_qspi_flash_resp;
    localparam logic [23:0] JEDEC = 24'hEF4018;
    localparam int          DUMMY = 8;
`ifdef QSPI_FLASH_RESP_QUAD_EN
    localparam bit QUAD_OK = 1'b1;
`else
    localparam bit QUAD_OK = 1'b0;
`endif

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          ncyc;
        logic [31:0] exp_data;
        int          exp_nreq;
        logic [3:0]  exp_oe;
        int          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck, spi_cs_n;
    logic [3:0]  spi_dq_i, spi_dq_o, spi_dq_oe;
    logic        mem_req, busy, cmd_err;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    int          cur = 0;
    int          hp = 6;
    logic [23:0] req_log[$];

    qspi_flash_resp dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_dq_i(spi_dq_i), .spi_dq_o(spi_dq_o), .spi_dq_oe(spi_dq_oe),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'h000011: return 8'h5A;
            24'h000000: return 8'h3C;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h6D;
        endcase
    endfunction

    function automatic logic [7:0] jedec_byte(input int k);
        logic [23:0] j;
        j = JEDEC;
        return j[23-8*k -: 8];
    endfunction

    // Flash behaviour from the protocol rules: which opcodes answer, what bytes stream out, which fetches happen.
    function automatic vec_t model(input logic [7:0] op, input logic [23:0] addr, input int ncyc);
        vec_t r;
        int   sup, rd, q, bpb, k, pos;
        logic [7:0] b;
        sup = (op == 8'h03 || op == 8'h0B || op == 8'h9F || (op == 8'h6B && QUAD_OK)) ? 1 : 0;
        rd  = (sup != 0 && op != 8'h9F) ? 1 : 0;
        q   = (op == 8'h6B && QUAD_OK) ? 1 : 0;
        bpb = (q != 0) ? 2 : 8;
        r.op       = op;
        r.addr     = addr;
        r.ncyc     = ncyc;
        r.exp_err  = (sup != 0) ? 0 : 1;
        r.exp_oe   = (sup == 0) ? 4'h0 : (q != 0) ? 4'hF : 4'h2;
        r.exp_nreq = (rd != 0) ? 1 + (ncyc + bpb - 1) / bpb : 0;
        r.exp_data = '0;
        if (sup != 0) begin
            for (int j = 0; j < ncyc; j++) begin
                k   = j / bpb;
                pos = j % bpb;
                b   = (rd != 0) ? mem_byte(addr + 24'(k)) : jedec_byte(k % 3);
                if (q != 0) r.exp_data = {r.exp_data[27:0], (pos == 0) ? b[7:4] : b[3:0]};
                else        r.exp_data = {r.exp_data[30:0], b[7-pos]};
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= mem_req ? mem_byte(mem_addr) : 8'h00;
        if (mem_req) req_log.push_back(mem_addr);
        if (cmd_err) err_cnt <= err_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, cur, act, exp);
        end
    endtask

    // One SCK period: fall, drive, hold low, sample just before the rise, hold high.
    task automatic cycle(input logic [3:0] d, output logic [3:0] sdq, output logic [3:0] soe);
        spi_sck  = 1'b0;
        spi_dq_i = d;
        wait_clk(hp);
        sdq = spi_dq_o;
        soe = spi_dq_oe;
        spi_sck = 1'b1;
        wait_clk(hp);
    endtask

    task automatic run_vec(input int idx, input vec_t v, input int simul);
        logic [31:0] got;
        logic [3:0]  sdq, soe;
        int          oe_bad, err0, nbad, ndum;
        bit          has_addr, quad_m;
        cur      = idx;
        got      = '0;
        oe_bad   = 0;
        nbad     = 0;
        has_addr = (v.op == 8'h03 || v.op == 8'h0B || v.op == 8'h6B);
        ndum     = (v.op == 8'h0B || v.op == 8'h6B) ? DUMMY : 0;
        quad_m   = (v.op == 8'h6B);
        req_log.delete();
        err0 = err_cnt;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b0;
        wait_clk(hp);
        for (int i = 0; i < 8; i++) begin
            cycle({3'b000, v.op[7-i]}, sdq, soe);
            if (soe !== 4'h0) oe_bad++;
        end
        if (has_addr) begin
            for (int i = 0; i < 24; i++) begin
                cycle({3'b000, v.addr[23-i]}, sdq, soe);
                if (soe !== 4'h0) oe_bad++;
            end
        end
        for (int i = 0; i < ndum; i++) begin
            cycle(4'h0, sdq, soe);
            if (soe !== 4'h0) oe_bad++;
        end
        for (int i = 0; i < v.ncyc; i++) begin
            cycle(4'h0, sdq, soe);
            if (soe !== v.exp_oe) oe_bad++;
            got = quad_m ? {got[27:0], sdq} : {got[30:0], sdq[1]};
        end
        chk("busy_active", busy, 1);
        spi_cs_n = 1'b1;
        if (simul != 0) spi_sck = 1'b0;
        wait_clk(4);
        chk("release_oe", spi_dq_oe, 0);
        chk("release_busy", busy, 0);
        wait_clk(4);
        spi_sck = 1'b0;
        wait_clk(2 * hp);
        if (v.exp_err == 0) chk("data", got, v.exp_data);
        chk("cmd_err_pulses", err_cnt - err0, v.exp_err);
        chk("oe_violations", oe_bad, 0);
        chk("mem_req_count", req_log.size(), v.exp_nreq);
        if (req_log.size() == v.exp_nreq) begin
            for (int i = 0; i < req_log.size(); i++)
                if (req_log[i] !== v.addr + 24'(i)) nbad++;
            chk("mem_req_addr", nbad, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[8];
        vec_t        v;
        logic [7:0]  op;
        logic [23:0] addr;
        int          sel, ncyc;

        tbl[0] = '{8'h03, 24'h000010, 16, 32'h0000A55A, 3, 4'h2, 0};
        tbl[1] = '{8'h9F, 24'h000000, 32, 32'hEF4018EF, 0, 4'h2, 0};
        tbl[2] = '{8'h0B, 24'hFFFFFF, 16, 32'h0000923C, 3, 4'h2, 0};
        tbl[3] = '{8'h55, 24'h000000, 16, 32'h00000000, 0, 4'h0, 1};
        tbl[4] = '{8'h9F, 24'h000000, 8,  32'h000000EF, 0, 4'h2, 0};
        tbl[5] = '{8'h03, 24'h000010, 4,  32'h0000000A, 2, 4'h2, 0};
        tbl[6] = '{8'h03, 24'h000011, 8,  32'h0000005A, 2, 4'h2, 0};
`ifdef QSPI_FLASH_RESP_QUAD_EN
        tbl[7] = '{8'h6B, 24'h000000, 2,  32'h0000003C, 2, 4'hF, 0};
`else
        tbl[7] = '{8'h6B, 24'h000000, 2,  32'h00000000, 0, 4'h0, 1};
`endif

        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_dq_i = 4'h0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        cur = -1;
        chk("rst_dq_o", spi_dq_o, 0);
        chk("rst_dq_oe", spi_dq_oe, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_err", cmd_err, 0);

        for (int i = 0; i < 8; i++) begin
            hp = 6;
            run_vec(i, tbl[i], 0);
        end

        // CS_n rises together with the SCK fall that would start the next byte: no extra fetch.
        hp = 7;
        run_vec(50, model(8'h03, 24'h000020, 8), 1);
        hp = 6;
        run_vec(51, model(8'h9F, 24'h000000, 16), 1);

        for (int r = 0; r < 10; r++) begin
            sel  = $urandom_range(0, 4);
            addr = 24'($urandom);
            case (sel)
                0: op = 8'h03;
                1: op = 8'h0B;
                2: op = 8'h9F;
                3: op = 8'h6B;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == 8'h03 || op == 8'h0B || op == 8'h9F || op == 8'h6B)
                        op = 8'($urandom_range(0, 255));
                end
            endcase
            ncyc = (op == 8'h6B) ? $urandom_range(1, 8) : $urandom_range(1, 24);
            hp   = $urandom_range(6, 9);
            v    = model(op, addr, ncyc);
            run_vec(100 + r, v, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
